// File: rtl/mem8x8_ctrl.sv
// mem8x8_ctrl: ready/req access sequencer driving the mem8x8 bytecell array with registered outputs.
// Define MEM8X8_CTRL_READBACK_EN to add a write-verify cycle that flags readback mismatches on err.
module mem8x8_ctrl #(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 3,
    parameter int NUM_CELLS   = 8,
    parameter int HOLD_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req,
    input  logic                 we,
    input  logic [ADDR_W-1:0]    addr,
    input  logic [DATA_W-1:0]    wdata,
    output logic                 ready,
    output logic                 done,
    output logic [DATA_W-1:0]    rdata,
    output logic                 err,
    output logic [NUM_CELLS-1:0] cell_sel,
    output logic                 cell_op,
    output logic [DATA_W-1:0]    cell_inp,
    input  logic [DATA_W-1:0]    cell_outp
);
    localparam int CW = HOLD_CYCLES > 1 ? $clog2(HOLD_CYCLES) : 1;
`ifdef MEM8X8_CTRL_READBACK_EN
    localparam bit READBACK = 1'b1;
`else
    localparam bit READBACK = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, SETUP, ACCESS, RELEASE, VERIFY, DONE} state_t;

    state_t                state, state_d;
    logic [CW-1:0]         cnt;
    logic                  we_q, we_n, accept, busy_d, op_d;
    logic [ADDR_W-1:0]     addr_q, addr_n;
    logic [DATA_W-1:0]     wdata_q, wdata_n, inp_d;
    logic [NUM_CELLS-1:0]  sel_d;

    assign accept  = req & ready;
    // Outputs are registered from the next state, so the accepting edge must see the incoming request fields.
    assign we_n    = accept ? we : we_q;
    assign addr_n  = accept ? addr : addr_q;
    assign wdata_n = accept ? wdata : wdata_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state <= state_d;
            cnt   <= (state == SETUP) ? CW'(HOLD_CYCLES - 1) : cnt - CW'(state == ACCESS);
            if (accept) begin
                we_q    <= we;
                addr_q  <= addr;
                wdata_q <= wdata;
            end
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    state_d = accept ? SETUP : IDLE;
            SETUP:   state_d = ACCESS;
            ACCESS:  state_d = (cnt == '0) ? RELEASE : ACCESS;
            RELEASE: state_d = (READBACK && we_q) ? VERIFY : DONE;
            VERIFY:  state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    // Out-of-range addresses shift the select bit off the top, leaving cell_sel all-zero.
    always_comb begin
        busy_d = state_d inside {SETUP, ACCESS, RELEASE, VERIFY};
        sel_d  = busy_d ? (NUM_CELLS'(1) << addr_n) : '0;
        op_d   = (state_d == ACCESS) && we_n;
        inp_d  = (busy_d && we_n) ? wdata_n : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready    <= 1'b1;
            done     <= 1'b0;
            rdata    <= '0;
            err      <= 1'b0;
            cell_sel <= '0;
            cell_op  <= 1'b0;
            cell_inp <= '0;
        end else begin
            ready    <= state_d == IDLE;
            done     <= state_d == DONE;
            cell_sel <= sel_d;
            cell_op  <= op_d;
            cell_inp <= inp_d;
            if (state == RELEASE && !we_q)
                rdata <= (|cell_sel) ? cell_outp : '0;
            if (accept)
                err <= 1'b0;
            else if (READBACK && state == VERIFY)
                err <= (|cell_sel) && (cell_outp != wdata_q);
        end
    end
endmodule

// File: tb/tb_mem8x8_ctrl.sv
// tb_mem8x8_ctrl: directed table-driven bench for mem8x8_ctrl with a bytecell array model.
// Latency is counted with the accepting edge as edge 1.
module tb_mem8x8_ctrl;
`ifdef MEM8X8_CTRL_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    logic       clk = 1'b0, rst = 1'b1, req = 1'b0, req6 = 1'b0, we = 1'b0, corrupt = 1'b0;
    logic [2:0] addr = '0;
    logic [7:0] wdata = '0;
    logic       ready, done, err, cell_op;
    logic [7:0] rdata, cell_sel, cell_inp, cell_outp;
    logic       ready6, done6, err6, cell_op6;
    logic [7:0] rdata6, cell_inp6;
    logic [5:0] cell_sel6;
    logic [7:0] mem [8] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'hCC};
    int errors = 0, checks = 0;

    always #5 clk = ~clk;

    mem8x8_ctrl dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .ready(ready), .done(done), .rdata(rdata), .err(err),
        .cell_sel(cell_sel), .cell_op(cell_op), .cell_inp(cell_inp), .cell_outp(cell_outp)
    );

    mem8x8_ctrl #(.NUM_CELLS(6)) dut6 (
        .clk(clk), .rst(rst), .req(req6), .we(we), .addr(addr), .wdata(wdata),
        .ready(ready6), .done(done6), .rdata(rdata6), .err(err6),
        .cell_sel(cell_sel6), .cell_op(cell_op6), .cell_inp(cell_inp6), .cell_outp(8'h5A)
    );

    always_comb begin
        cell_outp = 8'hEE;
        for (int i = 0; i < 8; i++)
            if (cell_sel[i]) cell_outp = mem[i];
    end

    always @(posedge clk)
        if (cell_op)
            for (int i = 0; i < 8; i++)
                if (cell_sel[i]) mem[i] <= cell_inp ^ {7'b0, corrupt};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic xact(input logic w, input logic [2:0] a, input logic [7:0] d,
                        output int lat, output int opc, output logic [7:0] sel_or,
                        output logic [7:0] inp_op, output logic rdy_done);
        @(negedge clk);
        chk("ready_idle", ready, 1);
        req = 1'b1; we = w; addr = a; wdata = d;
        @(posedge clk);
        #1 req = 1'b0;
        lat = 1; opc = 0; sel_or = '0; inp_op = '0; rdy_done = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            sel_or |= cell_sel;
            if (cell_op) begin
                opc++;
                inp_op = cell_inp;
            end
            if (done) begin
                rdy_done = ready;
                break;
            end
            @(posedge clk);
            lat++;
        end
    endtask

    task automatic xact6(input logic [2:0] a, output int lat, output logic [5:0] sel_or);
        @(negedge clk);
        req6 = 1'b1; we = 1'b0; addr = a;
        @(posedge clk);
        #1 req6 = 1'b0;
        lat = 1; sel_or = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            sel_or |= cell_sel6;
            if (done6) break;
            @(posedge clk);
            lat++;
        end
    endtask

    typedef struct {
        logic       w;
        logic [2:0] a;
        logic [7:0] d;
        logic [7:0] rd;
        logic [7:0] sel;
    } vec_t;

    initial begin
        vec_t       tv [8];
        int         lat, opc, dn;
        logic [7:0] sel_or, inp_op;
        logic [5:0] sel6;
        logic       rdy_done;
        tv[0] = '{1'b1, 3'd2, 8'hAA, 8'h00, 8'h04};
        tv[1] = '{1'b0, 3'd2, 8'h00, 8'hAA, 8'h04};
        tv[2] = '{1'b0, 3'd7, 8'h00, 8'hCC, 8'h80};
        tv[3] = '{1'b1, 3'd5, 8'h3C, 8'hCC, 8'h20};
        tv[4] = '{1'b0, 3'd5, 8'h00, 8'h3C, 8'h20};
        tv[5] = '{1'b1, 3'd0, 8'h01, 8'h3C, 8'h01};
        tv[6] = '{1'b0, 3'd0, 8'h00, 8'h01, 8'h01};
        tv[7] = '{1'b0, 3'd1, 8'h00, 8'h11, 8'h02};

        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", ready, 1);
        chk("rst_done", done, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_err", err, 0);
        chk("rst_sel", cell_sel, 0);
        chk("rst_op", cell_op, 0);
        chk("rst_inp", cell_inp, 0);

        // Async reset while the write strobe is up: no strobe edge, no done.
        req = 1'b1; we = 1'b1; addr = 3'd6; wdata = 8'h77;
        @(posedge clk);
        #1 req = 1'b0;
        for (int i = 0; i < 10 && !cell_op; i++) @(negedge clk);
        chk("midrst_op_seen", cell_op, 1);
        rst = 1'b1;
        #1;
        chk("midrst_sel", cell_sel, 0);
        chk("midrst_op", cell_op, 0);
        chk("midrst_inp", cell_inp, 0);
        chk("midrst_ready", ready, 1);
        @(negedge clk);
        rst = 1'b0;
        dn = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            dn += int'(done);
        end
        chk("midrst_no_done", dn, 0);
        chk("midrst_mem6", mem[6], 8'h16);

        for (int k = 0; k < 8; k++) begin
            xact(tv[k].w, tv[k].a, tv[k].d, lat, opc, sel_or, inp_op, rdy_done);
            chk($sformatf("v%0d_sel", k), sel_or, tv[k].sel);
            chk($sformatf("v%0d_opcycles", k), opc, tv[k].w ? 1 : 0);
            chk($sformatf("v%0d_inp", k), inp_op, tv[k].w ? tv[k].d : 8'h00);
            chk($sformatf("v%0d_latency", k), lat, (tv[k].w && RB) ? 5 : 4);
            chk($sformatf("v%0d_rdata", k), rdata, tv[k].rd);
            chk($sformatf("v%0d_err", k), err, 0);
            chk($sformatf("v%0d_ready_at_done", k), rdy_done, 0);
        end

        // req held high while busy with a different request: must be ignored.
        @(negedge clk);
        req = 1'b1; we = 1'b0; addr = 3'd1; wdata = 8'h00;
        @(posedge clk);
        #1 we = 1'b1; addr = 3'd3; wdata = 8'h99;
        dn = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) begin
                dn++;
                req = 1'b0;
            end
        end
        req = 1'b0; we = 1'b0;
        chk("busy_req_done_count", dn, 1);
        chk("busy_req_rdata", rdata, 8'h11);
        chk("busy_req_mem3", mem[3], 8'h13);
        chk("busy_req_ready", ready, 1);

        // Out-of-range address on a 6-cell controller.
        xact6(3'd1, lat, sel6);
        chk("n6_inrange_sel", sel6, 6'b000010);
        chk("n6_inrange_rdata", rdata6, 8'h5A);
        xact6(3'd6, lat, sel6);
        chk("n6_oor_sel", sel6, 0);
        chk("n6_oor_latency", lat, 4);
        chk("n6_oor_done", done6, 1);
        chk("n6_oor_rdata", rdata6, 0);

        // Write whose readback differs from the written data.
        corrupt = 1'b1;
        xact(1'b1, 3'd4, 8'hF0, lat, opc, sel_or, inp_op, rdy_done);
        corrupt = 1'b0;
        chk("rb_err", err, RB);
        chk("rb_latency", lat, RB ? 5 : 4);
        chk("rb_sel", sel_or, 8'h10);
        xact(1'b0, 3'd4, 8'h00, lat, opc, sel_or, inp_op, rdy_done);
        chk("rb_err_cleared", err, 0);
        chk("rb_rdata", rdata, 8'hF1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
